// File: rtl/ci_pkg.sv
// Shared definitions for the custom-instruction (CI) bus initiator:
// FSM state encoding, CI bus widths and the default timeout.
package ci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ci_state_t;

  localparam int CI_N_W          = 8;
  localparam int CI_DATA_W       = 32;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/ci_initiator.sv
// CI bus master. Takes one host request at a time, issues it on the CI bus,
// waits for ciDone (or a timeout) and holds the response until the host
// takes it. All outputs are registered; ciDone/ciResult are only sampled.
// Optional statistics counters are built when CI_INITIATOR_STATS_EN is defined.
//
// state | meaning
// IDLE  | ready for a host request
// ISSUE | one-cycle ciStart pulse; done may already arrive
// WAIT  | operands held, waiting for ciDone or timeout
// RESP  | response held on rsp* until rspReady
module ci_initiator
  import ci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                     systemClock,
  input  logic                     reset,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [CI_N_W-1:0]        reqN,
  input  logic [CI_DATA_W-1:0]     reqValueA,
  input  logic [CI_DATA_W-1:0]     reqValueB,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic [CI_DATA_W-1:0]     rspResult,
  output logic                     rspTimeout,
  output logic                     ciStart,
  output logic                     ciCke,
  output logic [CI_N_W-1:0]        ciN,
  output logic [CI_DATA_W-1:0]     ciValueA,
  output logic [CI_DATA_W-1:0]     ciValueB,
  input  logic [CI_DATA_W-1:0]     ciResult,
  input  logic                     ciDone,
  output logic [COUNTER_WIDTH-1:0] statTxCount,
  output logic [COUNTER_WIDTH-1:0] statTimeoutCount
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  ci_state_t              state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   req_ready_d, rsp_valid_d, rsp_timeout_d;
  logic                   ci_start_d, ci_cke_d;
  logic [CI_DATA_W-1:0]   rsp_result_d, ci_a_d, ci_b_d;
  logic [CI_N_W-1:0]      ci_n_d;
  logic                   expired;

  // cnt_q is 1 in ISSUE and counts ciCke cycles; >= also covers a limit of 1
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q >= TIMEOUT_LIMIT);

  // Next-state and next-output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = reqReady;
    rsp_valid_d   = rspValid;
    rsp_result_d  = rspResult;
    rsp_timeout_d = rspTimeout;
    ci_start_d    = 1'b0;
    ci_cke_d      = ciCke;
    ci_n_d        = ciN;
    ci_a_d        = ciValueA;
    ci_b_d        = ciValueB;
    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          state_d     = ST_ISSUE;
          req_ready_d = 1'b0;
          ci_start_d  = 1'b1;
          ci_cke_d    = 1'b1;
          ci_n_d      = reqN;
          ci_a_d      = reqValueA;
          ci_b_d      = reqValueB;
          cnt_d       = 16'd1;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (ciDone || expired) begin
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = ciDone ? ciResult : '0;
          rsp_timeout_d = !ciDone;
          ci_cke_d      = 1'b0;
          ci_n_d        = '0;
          ci_a_d        = '0;
          ci_b_d        = '0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (rspReady) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge systemClock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      reqReady   <= 1'b1;
      rspValid   <= 1'b0;
      rspResult  <= '0;
      rspTimeout <= 1'b0;
      ciStart    <= 1'b0;
      ciCke      <= 1'b0;
      ciN        <= '0;
      ciValueA   <= '0;
      ciValueB   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reqReady   <= req_ready_d;
      rspValid   <= rsp_valid_d;
      rspResult  <= rsp_result_d;
      rspTimeout <= rsp_timeout_d;
      ciStart    <= ci_start_d;
      ciCke      <= ci_cke_d;
      ciN        <= ci_n_d;
      ciValueA   <= ci_a_d;
      ciValueB   <= ci_b_d;
    end
  end

`ifdef CI_INITIATOR_STATS_EN
  logic enter_resp;
  assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);

  // Saturating completion / timeout counters, bumped on entry to RESP
  always_ff @(posedge systemClock) begin
    if (reset) begin
      statTxCount      <= '0;
      statTimeoutCount <= '0;
    end else if (enter_resp) begin
      if (!rsp_timeout_d && (statTxCount != '1))
        statTxCount <= statTxCount + 1'b1;
      if (rsp_timeout_d && (statTimeoutCount != '1))
        statTimeoutCount <= statTimeoutCount + 1'b1;
    end
  end
`else
  assign statTxCount      = '0;
  assign statTimeoutCount = '0;
`endif

endmodule

// File: tb/tb_ci_initiator.sv
// Directed bench for ci_initiator with a small CI responder model.
// Responder IDs: 0x05 done with ciStart (0x0A), 0x33 done 7 cycles after
// ciStart (0xDEADBEEF), 0x44 done 15 cycles after ciStart (0x12345678),
// anything else never answers.
module tb_ci_initiator;

  localparam int TMO = 16;
  localparam int CW  = 16;

  logic          systemClock = 1'b0;
  logic          reset = 1'b1;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [7:0]    reqN = '0;
  logic [31:0]   reqValueA = '0;
  logic [31:0]   reqValueB = '0;
  logic          rspValid;
  logic          rspReady = 1'b0;
  logic [31:0]   rspResult;
  logic          rspTimeout;
  logic          ciStart, ciCke;
  logic [7:0]    ciN;
  logic [31:0]   ciValueA, ciValueB;
  logic [31:0]   ciResult;
  logic          ciDone;
  logic [CW-1:0] statTxCount, statTimeoutCount;

  logic          force_done = 1'b0;
  int            kcnt;
  int            checks = 0;
  int            errors = 0;

  ci_initiator #(.TIMEOUT_CYCLES(TMO), .COUNTER_WIDTH(CW)) dut (
    .systemClock(systemClock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqN(reqN),
    .reqValueA(reqValueA), .reqValueB(reqValueB),
    .rspValid(rspValid), .rspReady(rspReady), .rspResult(rspResult),
    .rspTimeout(rspTimeout), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB), .ciResult(ciResult),
    .ciDone(ciDone), .statTxCount(statTxCount),
    .statTimeoutCount(statTimeoutCount)
  );

  always #5 systemClock = ~systemClock;

  // cycles elapsed since ciStart, as seen by the responder
  always @(posedge systemClock) begin
    if (ciStart)    kcnt <= 1;
    else if (ciCke) kcnt <= kcnt + 1;
    else            kcnt <= 0;
  end

  // responder model
  always_comb begin
    ciDone   = 1'b0;
    ciResult = 32'h0;
    if (force_done) begin
      ciDone   = 1'b1;
      ciResult = 32'hBAD0BAD0;
    end else if (ciN == 8'h05) begin
      ciDone   = ciStart & ciCke;
      ciResult = 32'h0000000A;
    end else if (ciN == 8'h33) begin
      ciDone   = ciCke && !ciStart && (kcnt == 7);
      ciResult = 32'hDEADBEEF;
    end else if (ciN == 8'h44) begin
      ciDone   = ciCke && !ciStart && (kcnt == 15);
      ciResult = 32'h12345678;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for rspValid; reports ciCke cycles,
  // ciStart cycles and whether ciN/A/B stayed at the request values.
  task automatic do_req(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                        output int cke, output int starts, output bit stable, output bit got);
    cke = 0; starts = 0; stable = 1'b1; got = 1'b0;
    reqN = n; reqValueA = a; reqValueB = b; reqValid = 1'b1;
    @(negedge systemClock);
    reqValid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rspValid) begin
        got = 1'b1;
        break;
      end
      if (ciCke) cke++;
      if (ciStart) starts++;
      if (ciCke && (ciN != n || ciValueA != a || ciValueB != b)) stable = 1'b0;
      @(negedge systemClock);
    end
  endtask

  task automatic ack();
    rspReady = 1'b1;
    @(negedge systemClock);
    rspReady = 1'b0;
  endtask

  int cke, starts, held_bad;
  bit stable, got;

  initial begin
    repeat (3) @(negedge systemClock);
    check("rst_reqReady", reqReady, 1);
    check("rst_rspValid", rspValid, 0);
    check("rst_ci", {ciStart, ciCke, ciN}, 0);
    check("rst_rsp", {rspTimeout, rspResult}, 0);
    reset = 1'b0;
    @(negedge systemClock);

    // zero-latency responder: ciStart at T+1, response at T+2
    reqN = 8'h05; reqValueA = 0; reqValueB = 0; reqValid = 1'b1;
    @(negedge systemClock);
    reqValid = 1'b0;
    check("zl_start", {ciStart, ciCke, ciN}, {2'b11, 8'h05});
    check("zl_reqReady", reqReady, 0);
    @(negedge systemClock);
    check("zl_rspValid", rspValid, 1);
    check("zl_result", {rspTimeout, rspResult}, {1'b0, 32'h0000000A});
    check("zl_ci_off", {ciStart, ciCke, ciN}, 0);
    ack();
    check("zl_idle", {rspValid, reqReady}, 2'b01);

    // multi-cycle responder
    do_req(8'h33, 32'h11111111, 32'h22222222, cke, starts, stable, got);
    check("mc_got", got, 1);
    check("mc_cke", cke, 8);
    check("mc_starts", starts, 1);
    check("mc_stable", stable, 1);
    check("mc_result", {rspTimeout, rspResult}, {1'b0, 32'hDEADBEEF});
    ack();

    // absent ID times out
    do_req(8'h7F, 32'hA5A5A5A5, 32'h5A5A5A5A, cke, starts, stable, got);
    check("to_got", got, 1);
    check("to_cke", cke, 16);
    check("to_result", {rspTimeout, rspResult}, {1'b1, 32'h0});
`ifdef CI_INITIATOR_STATS_EN
    check("to_stats", {statTxCount, statTimeoutCount}, {16'd2, 16'd1});
`else
    check("to_stats", {statTxCount, statTimeoutCount}, 0);
`endif
    ack();

    // done on the expiry cycle wins
    do_req(8'h44, 32'h3, 32'h4, cke, starts, stable, got);
    check("ex_got", got, 1);
    check("ex_cke", cke, 16);
    check("ex_result", {rspTimeout, rspResult}, {1'b0, 32'h12345678});
    ack();

    // response back-pressure with a pending request
    do_req(8'h05, 32'h0, 32'h0, cke, starts, stable, got);
    check("bp_first", {got, rspResult}, {1'b1, 32'h0000000A});
    reqN = 8'h33; reqValueA = 32'h77; reqValueB = 32'h88; reqValid = 1'b1;
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rspValid || reqReady || ciCke || rspResult != 32'h0000000A) held_bad++;
      @(negedge systemClock);
    end
    check("bp_held", held_bad, 0);
    rspReady = 1'b1;
    @(negedge systemClock);
    rspReady = 1'b0;
    check("bp_released", {rspValid, reqReady, ciStart}, 3'b010);
    @(negedge systemClock);
    reqValid = 1'b0;
    check("bp_second_issue", {ciStart, ciN, ciValueA}, {1'b1, 8'h33, 32'h77});
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rspValid) begin
        got = 1'b1;
        break;
      end
      @(negedge systemClock);
    end
    check("bp_second", {got, rspTimeout, rspResult}, {2'b10, 32'hDEADBEEF});
    ack();

    // reset in WAIT abandons the transaction
    do_req_start();
    reset = 1'b1;
    @(negedge systemClock);
    reset = 1'b0;
    check("mr_ci", {ciStart, ciCke}, 0);
    check("mr_rsp", {rspValid, reqReady}, 2'b01);
    check("mr_stats", {statTxCount, statTimeoutCount}, 0);
    force_done = 1'b1;
    held_bad = 0;
    repeat (3) begin
      @(negedge systemClock);
      if (rspValid || !reqReady || ciCke) held_bad++;
    end
    force_done = 1'b0;
    check("mr_late_done", held_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // start a never-answered request and leave it sitting in WAIT
  task automatic do_req_start();
    reqN = 8'h7F; reqValueA = 32'h1; reqValueB = 32'h2; reqValid = 1'b1;
    @(negedge systemClock);
    reqValid = 1'b0;
    repeat (3) @(negedge systemClock);
  endtask

endmodule
